// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the conditional-negate helper.
package muldiv_pkg;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_FIX,
      ST_DONE
   } state_e;

   // Helper works on a wide container; callers keep the low bits they need.
   // Two's-complement negation truncates cleanly, so this holds for 2*WIDTH <= MAX_W.
   localparam int MAX_W = 128;

   function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x,
                                                 input logic             neg);
      return neg ? -x : x;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring
// subtract-compare-shift for divide, on a 2*WIDTH accumulator.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   opnd,
   output logic [2*WIDTH-1:0] acc_nxt
);

   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shl;
   logic [WIDTH:0]   diff;

   always_comb begin
      addend  = acc[0] ? opnd : {WIDTH{1'b0}};
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      shl     = acc[2*WIDTH-1:WIDTH-1];
      diff    = shl - {1'b0, opnd};
      acc_nxt = {sum, acc[WIDTH-1:1]};
      if (is_div) begin
         // Partial remainder stays below 2*divisor, so a non-negative diff fits WIDTH bits.
         if (!diff[WIDTH]) acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else              acc_nxt = {shl[WIDTH-1:0],  acc[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; one bit per
// cycle on magnitudes, followed by a sign-fix cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             divzero_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic                 dz_q;
   logic [WIDTH-1:0]     hi_q, lo_q;
   logic                 is_div_q, neg_q, rem_neg_q;
   logic [2*WIDTH-1:0]   acc_q, acc_nxt;
   logic [WIDTH-1:0]     opnd_q;

   logic                 idle_or_done, accept, zero_div;
   logic                 a_neg, b_neg;
   logic [MAX_W-1:0]     a_abs_w, b_abs_w, prod_w, quot_w, rem_w;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH-1:0]     res_hi, res_lo;

   assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign accept       = start_i && idle_or_done;
   assign zero_div     = accept && op_i[1] && (data2_i == '0);

   // Operand capture: signed ops work on magnitudes, signs recorded for FIX
   assign a_neg   = op_i[0] && data1_i[WIDTH-1];
   assign b_neg   = op_i[0] && data2_i[WIDTH-1];
   assign a_abs_w = cond_neg(MAX_W'(data1_i), a_neg);
   assign b_abs_w = cond_neg(MAX_W'(data2_i), b_neg);
   assign a_mag   = a_abs_w[WIDTH-1:0];
   assign b_mag   = b_abs_w[WIDTH-1:0];

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div_q),
      .acc     (acc_q),
      .opnd    (opnd_q),
      .acc_nxt (acc_nxt)
   );

   // Sign fix: remainder follows the dividend, quotient/product follow sign XOR
   assign prod_w = cond_neg(MAX_W'(acc_q), neg_q);
   assign quot_w = cond_neg(MAX_W'(acc_q[WIDTH-1:0]), neg_q);
   assign rem_w  = cond_neg(MAX_W'(acc_q[2*WIDTH-1:WIDTH]), rem_neg_q);
   assign res_hi = is_div_q ? rem_w[WIDTH-1:0]  : prod_w[2*WIDTH-1:WIDTH];
   assign res_lo = is_div_q ? quot_w[WIDTH-1:0] : prod_w[WIDTH-1:0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept)                 state_d = zero_div ? ST_DONE : ST_BUSY;
            else if (state_q == ST_DONE) state_d = ST_IDLE;
         end
         ST_BUSY: if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
         ST_FIX:  state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               dz_q <= 1'b0;
               if (hi_we_i) hi_q <= wdata_i;
               if (lo_we_i) lo_q <= wdata_i;
               // Zero-divide result is written last so it beats MTHI/MTLO
               if (zero_div) begin
                  hi_q <= data1_i;
                  lo_q <= '1;
                  dz_q <= 1'b1;
               end else if (accept) begin
                  cnt_q <= CNT_W'(WIDTH);
               end
            end
            ST_BUSY: cnt_q <= cnt_q - CNT_W'(1);
            ST_FIX: begin
               hi_q <= res_hi;
               lo_q <= res_lo;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept && !zero_div) begin
         is_div_q  <= op_i[1];
         neg_q     <= a_neg ^ b_neg;
         rem_neg_q <= a_neg;
         opnd_q    <= op_i[1] ? b_mag : a_mag;
         acc_q     <= {{WIDTH{1'b0}}, op_i[1] ? a_mag : b_mag};
      end else if (state_q == ST_BUSY) begin
         acc_q <= acc_nxt;
      end
   end

   assign hi_o      = hi_q;
   assign lo_o      = lo_q;
   assign busy_o    = (state_q == ST_BUSY) || (state_q == ST_FIX);
   assign done_o    = (state_q == ST_DONE);
   assign divzero_o = (state_q == ST_DONE) && dz_q;

endmodule
